// File: rtl/multiplier_8x8_if.sv
// Operand/result bundle for the sequential shift-add multiplier.
// The requester drives start/a/b; the multiplier returns ab/done.
interface multiplier_8x8_if #(
    parameter int W = 8
);
    logic             start;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic [2*W-1:0]   ab;
    logic             done;

    modport master (
        output start,
        output a,
        output b,
        input  ab,
        input  done
    );

    modport slave (
        input  start,
        input  a,
        input  b,
        output ab,
        output done
    );
endinterface

// File: rtl/multiplier_8x8.sv
// Sequential unsigned W x W shift-add multiplier, one partial product per clock.
// Optional macro EARLY_TERM_EN: finish as soon as the remaining multiplier bits are all zero.
module multiplier_8x8 #(
    parameter int W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    multiplier_8x8_if.slave bus
);

    localparam int            CW       = $clog2(W) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    // LOAD: operands captured on the last edge, no step taken yet; RUN: iterating.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_RUN  = 2'b10
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [2*W-1:0]   ab_r;
    logic [2*W-1:0]   ab_s;
    logic [2*W-1:0]   mcand_r;
    logic [2*W-1:0]   mcand_s;
    logic [W-1:0]     mplier_r;
    logic [W-1:0]     mplier_s;
    logic [CW-1:0]    cnt_r;
    logic [CW-1:0]    cnt_s;
    logic             done_r;
    logic             done_s;
    logic             finish_s;

    // Next-state and datapath: start always wins and reloads, otherwise iterate while busy.
    always_comb begin
        state_s  = state_r;
        ab_s     = ab_r;
        mcand_s  = mcand_r;
        mplier_s = mplier_r;
        cnt_s    = cnt_r;
        done_s   = done_r;
        finish_s = 1'b0;

        if (bus.start) begin
            state_s  = ST_LOAD;
            mcand_s  = {{W{1'b0}}, bus.a};
            mplier_s = bus.b;
            ab_s     = {(2*W){1'b0}};
            cnt_s    = {CW{1'b0}};
            done_s   = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_s = ST_IDLE;
                end
                ST_LOAD, ST_RUN: begin
                    if (mplier_r[0]) begin
                        ab_s = ab_r + mcand_r;
                    end else begin
                        ab_s = ab_r;
                    end
                    mcand_s  = mcand_r << 1;
                    mplier_s = mplier_r >> 1;
                    cnt_s    = cnt_r + CW'(1);
`ifdef EARLY_TERM_EN
                    finish_s = (cnt_r == CNT_LAST) || (mplier_s == {W{1'b0}});
`else
                    finish_s = (cnt_r == CNT_LAST);
`endif
                    if (finish_s) begin
                        state_s = ST_IDLE;
                        done_s  = 1'b1;
                    end else begin
                        state_s = ST_RUN;
                        done_s  = 1'b0;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            ab_r     <= {(2*W){1'b0}};
            mcand_r  <= {(2*W){1'b0}};
            mplier_r <= {W{1'b0}};
            cnt_r    <= {CW{1'b0}};
            done_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            ab_r     <= ab_s;
            mcand_r  <= mcand_s;
            mplier_r <= mplier_s;
            cnt_r    <= cnt_s;
            done_r   <= done_s;
        end
    end

    assign bus.ab   = ab_r;
    assign bus.done = done_r;

endmodule

// File: tb/tb_multiplier_8x8.sv
// Randomized self-checking bench for multiplier_8x8 against an arithmetic reference model.
// Honours EARLY_TERM_EN for the expected latency.
module tb_multiplier_8x8;

    localparam int W = 8;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    multiplier_8x8_if #(.W(W)) bus ();

    multiplier_8x8 #(.W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected number of steps from the first start-low edge to done.
    function automatic int ref_latency(input logic [W-1:0] bv);
        int lat;
`ifdef EARLY_TERM_EN
        lat = 1;
        for (int i = 0; i < W; i++) begin
            if (bv[i]) lat = i + 1;
        end
`else
        lat = W;
`endif
        return lat;
    endfunction

    task automatic check_out(input string name, input int exp_ab, input logic exp_done);
        n_cmp++;
        if (bus.ab !== 16'(exp_ab)) begin
            n_bad++;
            $display("FAIL %s: ab=%0d expected %0d", name, bus.ab, exp_ab);
        end
        n_cmp++;
        if (bus.done !== exp_done) begin
            n_bad++;
            $display("FAIL %s: done=%0b expected %0b", name, bus.done, exp_done);
        end
    endtask

    // Load for 'hold' cycles, then follow the run: partial sum after k steps is a*(b mod 2^k).
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tbv, input int hold,
                          input string name);
        int lat;
        int k;
        bus.start = 1'b1;
        bus.a     = ta;
        bus.b     = tbv;
        repeat (hold) tick();
        check_out({name, "_load"}, 0, 1'b0);
        bus.start = 1'b0;
        bus.a     = W'($urandom);
        bus.b     = W'($urandom);
        lat = ref_latency(tbv);
        for (int i = 1; i <= lat + 3; i++) begin
            tick();
            k = (i < lat) ? i : lat;
            check_out(name, int'(ta) * (int'(tbv) % (1 << k)), (i >= lat));
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = 8'd0;
        bus.b     = 8'd0;
        tick();
        tick();
        check_out("reset", 0, 1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.a = W'($urandom);
            bus.b = W'($urandom);
            tick();
            check_out("idle_no_start", 0, 1'b0);
        end
    endtask

    task automatic test_directed();
        run_op(8'd26, 8'd80, 5, "mul_26x80");
        run_op(8'd255, 8'd255, 1, "mul_255x255");
        run_op(8'd0, 8'd123, 2, "mul_0x123");
        run_op(8'd123, 8'd0, 1, "mul_123x0");
        run_op(8'd1, 8'd128, 1, "mul_1x128");
    endtask

    task automatic test_abort();
        bus.start = 1'b1;
        bus.a     = 8'd26;
        bus.b     = 8'd80;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (bus.done !== 1'b0) begin
                n_bad++;
                $display("FAIL abort_pre: done=%0b expected 0", bus.done);
            end
        end
        run_op(8'd3, 8'd7, 1, "abort_reload");
    endtask

    task automatic test_reset_mid_run();
        bus.start = 1'b1;
        bus.a     = 8'd200;
        bus.b     = 8'd201;
        tick();
        bus.start = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0;
        tick();
        check_out("reset_mid_run", 0, 1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check_out("after_reset_idle", 0, 1'b0);
        end
    endtask

    task automatic test_back_to_back();
        run_op(8'd26, 8'd80, 5, "b2b_first");
        run_op(8'd1, 8'd1, 1, "b2b_second");
    endtask

    task automatic test_random();
        for (int n = 0; n < 25; n++) begin
            run_op(W'($urandom), W'($urandom), int'($urandom_range(3, 1)), "random");
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_directed();
        test_abort();
        test_reset_mid_run();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
